// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants and types for the character move sequencer
// Holds character indices, direction encodings, FSM state type, default
// screen size and the per-character reset positions.
package game_pkg;

    localparam logic [1:0] MAGE     = 2'd0;
    localparam logic [1:0] GUNMAN   = 2'd1;
    localparam logic [1:0] SWORDMAN = 2'd2;
    localparam logic [1:0] FISTMAN  = 2'd3;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int SCREEN_W_DEF = 96;
    localparam int SCREEN_H_DEF = 64;

    // Packed in port order: character i occupies [7i+6:7i] / [6i+5:6i].
    // mage (8,8), gunman (80,8), swordman (8,48), fistman (80,48)
    localparam logic [27:0] RST_POS_X = {7'd80, 7'd8, 7'd80, 7'd8};
    localparam logic [23:0] RST_POS_Y = {6'd48, 6'd48, 6'd8, 6'd8};

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin picker
// Ports:
//   req   in  4  pending requests
//   last  in  2  index served most recently; search starts at last+1
//   grant out 4  one-hot winner (zero when no request)
//   valid out 1  at least one request pending
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        grant = 4'b0000;
        valid = 1'b0;
        idx   = 2'd0;
        // Offsets 1..4; offset 4 wraps to last itself, so it is checked last.
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// rtl/move_arbiter.sv - round-robin movement sequencer sharing one collision test port
// Optional feature: MOVE_ARB_HIT_STUN_EN (per-character stun after a hit).
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   move_req[3:0]           level request per character
//   move_dir[7:0]           2-bit direction per character
//   move_ack[3:0], move_ok  one-cycle result of the served request
//   busy                    high in TEST and RESP
//   test_x, test_y          candidate position to the detector
//   character_to_move       granted character index to the detector
//   move_allowed            detector verdict for the current test port
//   hit[3:0]                per-character hit flags from the detector
//   pos_x[27:0], pos_y[23:0] packed character positions
module move_arbiter
    import game_pkg::*;
#(
    parameter int          SCREEN_W    = SCREEN_W_DEF,
    parameter int          SCREEN_H    = SCREEN_H_DEF,
    parameter int          CHAR_W      = 8,
    parameter int          CHAR_H      = 8,
    parameter int          STEP        = 1,
    parameter logic [15:0] STUN_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  move_req,
    input  logic [7:0]  move_dir,
    output logic [3:0]  move_ack,
    output logic        move_ok,
    output logic        busy,
    output logic [6:0]  test_x,
    output logic [5:0]  test_y,
    output logic [1:0]  character_to_move,
    input  logic        move_allowed,
    input  logic [3:0]  hit,
    output logic [27:0] pos_x,
    output logic [23:0] pos_y
);

    arb_state_e  state_q, state_d;
    logic [1:0]  rr_last_q, rr_last_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  ctm_q, ctm_d;
    logic [6:0]  test_x_q, test_x_d;
    logic [5:0]  test_y_q, test_y_d;
    logic        oob_q, oob_d;
    logic [3:0]  move_ack_q, move_ack_d;
    logic        move_ok_q, move_ok_d;
    logic [27:0] pos_x_q, pos_x_d;
    logic [23:0] pos_y_q, pos_y_d;

    logic [3:0]  arb_grant;
    logic        arb_valid;
    logic [1:0]  pick_idx;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;
    logic [1:0]  cur_dir;
    logic [7:0]  cx;
    logic [6:0]  cy;
    logic        oob_c;
    logic [6:0]  cand_x;
    logic [5:0]  cand_y;
    logic        stunned;
    logic        commit_ok;

    rr_arbiter4 u_rr (
        .req   (move_req),
        .last  (rr_last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        pick_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (arb_grant[i]) pick_idx = 2'(i);
        end
    end

    // Candidate position in widened arithmetic so that under/overflow is
    // detected instead of wrapping; an out-of-bounds move tests the
    // unmodified position and is rejected.
    always_comb begin
        cur_x   = pos_x_q[7*pick_idx +: 7];
        cur_y   = pos_y_q[6*pick_idx +: 6];
        cur_dir = move_dir[2*pick_idx +: 2];
        cx      = {1'b0, cur_x};
        cy      = {1'b0, cur_y};
        oob_c   = 1'b0;
        case (dir_e'(cur_dir))
            DIR_UP: begin
                if (cy < 7'(STEP)) oob_c = 1'b1;
                else               cy    = cy - 7'(STEP);
            end
            DIR_DOWN: begin
                cy = cy + 7'(STEP);
                if (cy + 7'(CHAR_H) > 7'(SCREEN_H)) oob_c = 1'b1;
            end
            DIR_LEFT: begin
                if (cx < 8'(STEP)) oob_c = 1'b1;
                else               cx    = cx - 8'(STEP);
            end
            default: begin
                cx = cx + 8'(STEP);
                if (cx + 8'(CHAR_W) > 8'(SCREEN_W)) oob_c = 1'b1;
            end
        endcase
        cand_x = oob_c ? cur_x : cx[6:0];
        cand_y = oob_c ? cur_y : cy[5:0];
    end

`ifdef MOVE_ARB_HIT_STUN_EN
    logic [15:0] stun_q [4];
    logic [15:0] stun_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (hit[i])                stun_d[i] = STUN_CYCLES;
            else if (stun_q[i] != '0)  stun_d[i] = stun_q[i] - 16'd1;
            else                       stun_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) stun_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) stun_q[i] <= stun_d[i];
        end
    end

    assign stunned = (stun_q[ctm_q] != '0);
`else
    logic unused_cfg;
    assign unused_cfg = ^{hit, STUN_CYCLES};
    assign stunned    = 1'b0;
`endif

    assign commit_ok = move_allowed & ~oob_q & ~stunned;

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        grant_d    = grant_q;
        ctm_d      = ctm_q;
        test_x_d   = test_x_q;
        test_y_d   = test_y_q;
        oob_d      = oob_q;
        move_ack_d = 4'b0000;
        move_ok_d  = 1'b0;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d  = arb_grant;
                    ctm_d    = pick_idx;
                    test_x_d = cand_x;
                    test_y_d = cand_y;
                    oob_d    = oob_c;
                    state_d  = TEST;
                end
            end
            TEST: begin
                if (commit_ok) begin
                    pos_x_d[7*ctm_q +: 7] = test_x_q;
                    pos_y_d[6*ctm_q +: 6] = test_y_q;
                end
                move_ack_d = grant_q;
                move_ok_d  = commit_ok;
                rr_last_d  = ctm_q;
                state_d    = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_last_q  <= 2'd3;
            grant_q    <= 4'b0000;
            ctm_q      <= 2'd0;
            test_x_q   <= 7'd0;
            test_y_q   <= 6'd0;
            oob_q      <= 1'b0;
            move_ack_q <= 4'b0000;
            move_ok_q  <= 1'b0;
            pos_x_q    <= RST_POS_X;
            pos_y_q    <= RST_POS_Y;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            grant_q    <= grant_d;
            ctm_q      <= ctm_d;
            test_x_q   <= test_x_d;
            test_y_q   <= test_y_d;
            oob_q      <= oob_d;
            move_ack_q <= move_ack_d;
            move_ok_q  <= move_ok_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
        end
    end

    assign move_ack          = move_ack_q;
    assign move_ok           = move_ok_q;
    assign busy              = (state_q == TEST) || (state_q == RESP);
    assign test_x            = test_x_q;
    assign test_y            = test_y_q;
    assign character_to_move = ctm_q;
    assign pos_x             = pos_x_q;
    assign pos_y             = pos_y_q;

endmodule

// File: tb/tb_move_arbiter.sv
// tb/tb_move_arbiter.sv - self-checking bench for move_arbiter
module tb_move_arbiter;

`ifdef MOVE_ARB_HIT_STUN_EN
    localparam logic [15:0] STUN = 16'd4;
`else
    localparam logic [15:0] STUN = 16'd50000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  move_req;
    logic [7:0]  move_dir;
    logic [3:0]  move_ack;
    logic        move_ok;
    logic        busy;
    logic [6:0]  test_x;
    logic [5:0]  test_y;
    logic [1:0]  character_to_move;
    logic        move_allowed;
    logic [3:0]  hit;
    logic [27:0] pos_x;
    logic [23:0] pos_y;

    move_arbiter #(.STUN_CYCLES(STUN)) dut (
        .clk               (clk),
        .reset             (reset),
        .move_req          (move_req),
        .move_dir          (move_dir),
        .move_ack          (move_ack),
        .move_ok           (move_ok),
        .busy              (busy),
        .test_x            (test_x),
        .test_y            (test_y),
        .character_to_move (character_to_move),
        .move_allowed      (move_allowed),
        .hit               (hit),
        .pos_x             (pos_x),
        .pos_y             (pos_y)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: plain integer positions and the last served index.
    int mx [4];
    int my [4];
    int last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mx[0] = 8;  my[0] = 8;
        mx[1] = 80; my[1] = 8;
        mx[2] = 8;  my[2] = 48;
        mx[3] = 80; my[3] = 48;
        last  = 3;
    endtask

    task automatic check_pos(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_x"}, 32'(pos_x[7*i +: 7]), 32'(mx[i]));
            check({tag, "_y"}, 32'(pos_y[6*i +: 6]), 32'(my[i]));
        end
    endtask

    function automatic int pick(input logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One full grant from IDLE: drive, TEST, RESP, back to IDLE.
    task automatic serve(input logic [3:0] req, input logic [7:0] dirs, input logic allowed,
                         input bit stunned, input bit hold, input bit scramble);
        int c, d, nx, ny;
        bit oob, ok;
        c  = pick(req);
        d  = int'(dirs[2*c +: 2]);
        nx = mx[c];
        ny = my[c];
        if (d == 0) ny = ny - 1;
        else if (d == 1) ny = ny + 1;
        else if (d == 2) nx = nx - 1;
        else nx = nx + 1;
        oob = (nx < 0) || (ny < 0) || (nx + 8 > 96) || (ny + 8 > 64);
        if (oob) begin
            nx = mx[c];
            ny = my[c];
        end
        ok = allowed && !oob && !stunned;
        move_req     = req;
        move_dir     = dirs;
        move_allowed = allowed;
        step();
        check("busy_test", 32'(busy), 32'd1);
        check("ack_in_test", 32'(move_ack), 32'd0);
        check("character_to_move", 32'(character_to_move), 32'(c));
        check("test_x", 32'(test_x), 32'(nx));
        check("test_y", 32'(test_y), 32'(ny));
        if (scramble) begin
            move_req = 4'($urandom);
            move_dir = 8'($urandom);
        end
        step();
        if (ok) begin
            mx[c] = nx;
            my[c] = ny;
        end
        last = c;
        check("move_ack", 32'(move_ack), 32'(1 << c));
        check("move_ok", 32'(move_ok), 32'(ok));
        check("busy_resp", 32'(busy), 32'd1);
        check_pos("pos");
        if (!hold) move_req = 4'b0000;
        step();
        check("ack_idle", 32'(move_ack), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        move_req     = 4'b0000;
        move_dir     = 8'h00;
        move_allowed = 1'b0;
        hit          = 4'b0000;
        model_reset();
        step();
        step();
        check("rst_ack", 32'(move_ack), 32'd0);
        check("rst_ok", 32'(move_ok), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_test_x", 32'(test_x), 32'd0);
        check("rst_test_y", 32'(test_y), 32'd0);
        check("rst_ctm", 32'(character_to_move), 32'd0);
        check_pos("rst_pos");
        reset = 1'b0;
        step();
        check("idle_no_req", 32'(busy), 32'd0);

        // Held requests from all four: strict 0,1,2,3 rotation, 3 cycles apart.
        move_req = 4'hF;
        for (int k = 0; k < 8; k++) serve(4'hF, 8'b11_10_01_00, 1'b0, 1'b0, 1'b1, 1'b0);
        move_req = 4'b0000;

        // Mage right, allowed: 8 -> 9.
        serve(4'b0001, 8'b00_00_00_11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mage_x_9", 32'(pos_x[6:0]), 32'd9);
        // Gunman left, detector refuses: test_x 79, x stays 80.
        serve(4'b0010, 8'b00_00_10_00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("gunman_x_80", 32'(pos_x[13:7]), 32'd80);

        // Mage walks to the left edge, then one more step is rejected.
        for (int k = 0; k < 10; k++) serve(4'b0001, 8'b00_00_00_10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mage_x_0", 32'(pos_x[6:0]), 32'd0);
        // Mage walks to the right edge (x=88), then one more step is rejected.
        for (int k = 0; k < 89; k++) serve(4'b0001, 8'b00_00_00_11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mage_x_88", 32'(pos_x[6:0]), 32'd88);
        // Swordman walks down to the bottom edge (y=56) and stops.
        for (int k = 0; k < 10; k++) serve(4'b0100, 8'b00_01_00_00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sword_y_56", 32'(pos_y[17:12]), 32'd56);

        // Reset while a move is in TEST: no ack, positions back to reset.
        move_req     = 4'b0001;
        move_dir     = 8'b00_00_00_10;
        move_allowed = 1'b1;
        step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_ack", 32'(move_ack), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check_pos("mid_rst_pos");
        step();
        check("mid_rst_ack_next", 32'(move_ack), 32'd0);
        check("mid_rst_ok_next", 32'(move_ok), 32'd0);
        move_req = 4'b0000;
        reset    = 1'b0;
        step();
        check("post_rst_ack", 32'(move_ack), 32'd0);
        serve(4'b0001, 8'b00_00_00_11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_mage_x", 32'(pos_x[6:0]), 32'd9);

`ifdef MOVE_ARB_HIT_STUN_EN
        hit = 4'b0100;
        step();
        hit = 4'b0000;
        serve(4'b0100, 8'b00_00_00_00, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        serve(4'b0100, 8'b00_00_00_00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sword_unstunned_y", 32'(pos_y[17:12]), 32'd47);
`endif

        // Randomised traffic; requests/directions scrambled while in flight.
        for (int n = 0; n < 80; n++) begin
`ifndef MOVE_ARB_HIT_STUN_EN
            hit = 4'($urandom);
`endif
            serve(4'($urandom_range(1, 15)), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
